// File: rtl/game_animator.sv
// Sprite/obstacle pixel colouring with a PLAY -> DYING -> DONE collision FSM.
// Optional obstacle flicker is built only when GAME_ANIMATOR_FLICKER_EN is defined.
//   state | meaning
//   PLAY  | normal play, collisions detected
//   DYING | player blinks blue, counting frames
//   DONE  | player solid blue, game_over held until reset
module game_animator #(
  parameter int NUM_OBS    = 4,
  parameter int FLICK_LOG2 = 3,
  parameter int DIE_FRAMES = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  on,
  input  logic [9:0]            x,
  input  logic [8:0]            y,
  input  logic                  frame_end,
  input  logic [9:0]            barry_x0,
  input  logic [9:0]            barry_x1,
  input  logic [8:0]            barry_y0,
  input  logic [8:0]            barry_y1,
  input  logic [NUM_OBS*10-1:0] obs_x0,
  input  logic [NUM_OBS*10-1:0] obs_x1,
  input  logic [NUM_OBS*9-1:0]  obs_y0,
  input  logic [NUM_OBS*9-1:0]  obs_y1,
  input  logic [NUM_OBS-1:0]    obs_en,
  output logic [7:0]            r,
  output logic [7:0]            g,
  output logic [7:0]            b,
  output logic                  game_over,
  output logic [2:0]            hit_idx
);

  typedef enum logic [1:0] {PLAY, DYING, DONE} state_t;

  localparam logic [23:0] COL_FIRE  = 24'hFF8000;
  localparam logic [23:0] COL_HEAD  = 24'hA4674A;
  localparam logic [23:0] COL_TORSO = 24'h0A0A80;
  localparam logic [23:0] COL_JET   = 24'h141414;
  localparam logic [23:0] COL_YEL   = 24'hFFFF00;
  localparam logic [23:0] COL_BG    = 24'hF0F0F0;
  localparam logic [23:0] COL_BLUE  = 24'h0000FF;

  state_t       state, next_state;
  logic [7:0]   die_cnt;
  logic [23:0]  rgb_q, rgb_next;
  logic [2:0]   hit_first;
  logic [NUM_OBS-1:0] obs_hit;
  logic         flick_phase;

  logic [10:0] xe, ye, bx0, bx1, by0, by1, dx, fire_dy;
  logic signed [12:0] jet_dy;
  logic signed [17:0] jet_lhs, jet_rhs;
  logic [14:0]  fire_lhs, fire_rhs;
  logic         in_left, in_right, jet, fire, torso, head, player, player_draw;

  assign xe  = {1'b0, x};
  assign ye  = {2'b00, y};
  assign bx0 = {1'b0, barry_x0};
  assign bx1 = {1'b0, barry_x1};
  assign by0 = {2'b00, barry_y0};
  assign by1 = {2'b00, barry_y1};
  assign dx  = xe - bx0;

  // Jetpack slope term may go negative below y1-15; keep it signed so it never wraps.
  assign jet_dy   = $signed({2'b00, by1}) - 13'sd15 - $signed({2'b00, ye});
  assign jet_lhs  = 18'(jet_dy) * 18'sd10;
  assign jet_rhs  = $signed({7'b0, dx}) * 18'sd30;
  assign fire_dy  = by1 - ye;
  assign fire_lhs = {4'b0, fire_dy} * 15'd10;
  assign fire_rhs = {4'b0, dx} * 15'd15;

  assign in_left  = (xe >= bx0) && (xe <= bx0 + 11'd10);
  assign in_right = (xe >= bx0 + 11'd10) && (xe <= bx1);
  assign jet   = in_left && (ye >= by0 + 11'd15) && (ye <= by0 + 11'd45) && (jet_lhs <= jet_rhs);
  assign fire  = in_left && (ye >= by0 + 11'd45) && (ye <= by1) && (fire_lhs >= fire_rhs);
  assign torso = in_right && (ye >= by0 + 11'd15) && (ye <= by1);
  assign head  = in_right && (ye >= by0) && (ye <= by0 + 11'd15);
  assign player      = jet || fire || torso || head;
  assign player_draw = (fire && on) || head || torso || jet;

  always_comb begin
    obs_hit = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      obs_hit[i] = obs_en[i]
                && (x >= obs_x0[i*10 +: 10]) && (x <= obs_x1[i*10 +: 10])
                && (y >= obs_y0[i*9 +: 9])   && (y <= obs_y1[i*9 +: 9]);
    end
  end

  always_comb begin
    hit_first = '0;
    for (int i = NUM_OBS - 1; i >= 0; i--) begin
      if (obs_hit[i]) hit_first = 3'(i);
    end
  end

`ifdef GAME_ANIMATOR_FLICKER_EN
  logic [FLICK_LOG2:0] flick_cnt;

  always_ff @(posedge clk) begin
    if (reset)          flick_cnt <= '0;
    else if (frame_end) flick_cnt <= flick_cnt + 1'b1;
  end

  assign flick_phase = flick_cnt[FLICK_LOG2];
`else
  assign flick_phase = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      PLAY:    if (player && |obs_hit) next_state = DYING;
      DYING:   if (frame_end && die_cnt == 8'(DIE_FRAMES - 1)) next_state = DONE;
      DONE:    next_state = DONE;
      default: next_state = PLAY;
    endcase
  end

  always_comb begin
    rgb_next = COL_BG;
    if (fire && on)   rgb_next = COL_FIRE;
    else if (head)    rgb_next = COL_HEAD;
    else if (torso)   rgb_next = COL_TORSO;
    else if (jet)     rgb_next = COL_JET;
    else if (|obs_hit) rgb_next = flick_phase ? COL_YEL : COL_FIRE;
    if (player_draw && ((state == DONE) || (state == DYING && !die_cnt[0])))
      rgb_next = COL_BLUE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PLAY;
      die_cnt   <= '0;
      hit_idx   <= '0;
      game_over <= 1'b0;
      rgb_q     <= COL_BG;
    end else begin
      state     <= next_state;
      game_over <= (next_state == DONE);
      rgb_q     <= rgb_next;
      if (state == PLAY && next_state == DYING) hit_idx <= hit_first;
      if (state == DYING && frame_end) die_cnt <= die_cnt + 8'd1;
    end
  end

  assign {r, g, b} = rgb_q;

endmodule

// File: doc/game_animator.md
GAME_ANIMATOR -- requirements
Module: game_animator

Interface
REQ-001 Parameter NUM_OBS, default 4: number of rectangular obstacles, range 1..8.
REQ-002 Parameter FLICK_LOG2, default 3: obstacle flicker half-period is 2^FLICK_LOG2 frames.
REQ-003 Parameter DIE_FRAMES, default 60: number of frames spent in the DYING state, range 1..255.
REQ-004 clk  input  1  the single clock; all state is updated on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 on  input  1  jetpack thrust; enables drawing of the fire region.
REQ-007 x  input  10  current pixel column.
REQ-008 y  input  9  current pixel row.
REQ-009 frame_end  input  1  one-cycle pulse issued after the last pixel of each frame.
REQ-010 barry_x0, barry_x1  input  10 each  player bounding box, left and right columns, inclusive.
REQ-011 barry_y0, barry_y1  input  9 each  player bounding box, top and bottom rows, inclusive.
REQ-012 obs_x0, obs_x1  input  NUM_OBS*10  packed obstacle columns, obstacle i occupying bits [10i+9:10i].
REQ-013 obs_y0, obs_y1  input  NUM_OBS*9  packed obstacle rows, same packing at 9 bits per obstacle.
REQ-014 obs_en  input  NUM_OBS  per-obstacle enable; a disabled obstacle is neither drawn nor collided with.
REQ-015 r, g, b  output  8 each  registered pixel colour.
REQ-016 game_over  output  1  registered; high in the DONE state.
REQ-017 hit_idx  output  3  index of the obstacle that caused the collision.

Function
REQ-018 Player region tests SHALL be the following, all computed in 11-bit unsigned arithmetic with no wrap:
- jetpack: x in [x0, x0+10], y in [y0+15, y0+45], and (y1-15-y)*10 <= (x-x0)*30.
- fire: x in [x0, x0+10], y in [y0+45, y1], and (y1-y)*10 >= (x-x0)*15.
- torso: x in [x0+10, x1], y in [y0+15, y1].
- head: x in [x0+10, x1], y in [y0, y0+15].
REQ-019 Obstacle i SHALL be considered hit when obs_en[i] is set and x and y fall inside its inclusive box.
REQ-020 Colour priority SHALL be, highest first:
- fire & on: FF8000.
- head: A4674A.
- torso: 0A0A80.
- jetpack: 141414.
- obstacle: orange FF8000 when the flicker phase is 0, yellow FFFF00 when it is 1.
- background: F0F0F0.
REQ-021 r, g and b SHALL be registered, giving exactly 1 cycle of latency from x/y to colour.
REQ-022 The state machine SHALL have three states: PLAY, DYING, DONE.
REQ-023 In PLAY, a collision (any player region and any obstacle hit on the same pixel) SHALL cause a transition to DYING on the next edge.
REQ-024 On that transition, hit_idx SHALL latch the lowest-indexed obstacle hit on that pixel.
REQ-025 In DYING, a frame counter SHALL increment on each frame_end; when the count reaches DIE_FRAMES the state SHALL become DONE.
REQ-026 In DYING, player pixels SHALL be drawn blue 0000FF on even counts and with their normal colours on odd counts.
REQ-027 In DONE, player pixels SHALL be drawn 0000FF, game_over SHALL be 1, and the state SHALL hold until reset.
REQ-028 Collisions in DYING or DONE SHALL be ignored, and hit_idx SHALL hold its value.
REQ-029 The flicker counter SHALL be FLICK_LOG2+1 bits, increment on frame_end in every state, and wrap freely; the phase is its MSB.
REQ-030 When a collision and frame_end occur in the same cycle, both the state transition and the counter update SHALL take effect.

Reset
REQ-031 On reset, all registers SHALL clear and the state SHALL be PLAY:
- r, g, b = F0F0F0.
- game_over = 0.
- hit_idx = 0.
- both counters = 0.
REQ-032 Reset asserted mid-DYING or in DONE SHALL return the block to PLAY on the next edge, dominating any collision or frame_end in that cycle.

Configuration
REQ-033 With GAME_ANIMATOR_FLICKER_EN defined, obstacles SHALL alternate colour as in REQ-020.
REQ-034 Without GAME_ANIMATOR_FLICKER_EN, obstacles SHALL be constant orange FF8000 and the flicker counter SHALL not be built; all other behaviour is unchanged.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
- Pixel (x0+20, y0+5) with no obstacle -> colour A4674A one cycle later.
- Obstacle 2 box overlapping the torso, scan the overlap -> DYING next edge, hit_idx=2.
- Obstacles 1 and 3 both overlapping the same pixel -> hit_idx=1.
- DIE_FRAMES=2, two frame_end pulses in DYING -> game_over=1 on the next edge; player pixels 0000FF.
- FLICKER_EN defined, FLICK_LOG2=0 -> obstacle colour toggles between FF8000 and FFFF00 on every frame_end.
- Reset asserted in DONE together with a collision -> PLAY, game_over=0, r/g/b=F0F0F0.
